// File: rtl/pe_tile_sequencer.sv
// Loop-nest sequencer for one convolution layer: walks the tile index space, issues one
// weight/activation buffer read per step and pipelines mac_en/tile_done_flag behind the
// registered buffer output.
module pe_tile_sequencer #(
    parameter int unsigned KX_W   = 4,
    parameter int unsigned KY_W   = 4,
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 8,
    parameter int unsigned N_W    = 8,
    parameter int unsigned I_W    = 8,
    parameter int unsigned X_STEP = 4,
    parameter int unsigned N_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KX_W-1:0] kx,
    input  logic [KY_W-1:0] ky,
    input  logic [X_W-1:0]  x,
    input  logic [Y_W-1:0]  y,
    input  logic [N_W-1:0]  nc,
    input  logic [I_W-1:0]  ic,
    input  logic            sparse_stall,
    input  logic            mult_done,
    output logic            busy,
    output logic            done,
    output logic            buf_rd_en,
    output logic [KX_W-1:0] kkx,
    output logic [KY_W-1:0] kky,
    output logic [X_W-1:0]  xx,
    output logic [Y_W-1:0]  yy,
    output logic [N_W-1:0]  nn,
    output logic [I_W-1:0]  ii,
    output logic            mac_en,
    output logic            tile_done_flag
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched layer configuration
    logic [KX_W-1:0] kx_q;
    logic [KY_W-1:0] ky_q;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [N_W-1:0]  nc_q;
    logic [I_W-1:0]  ic_q;

    // Index counters
    logic [KX_W-1:0] kkx_q, kkx_d;
    logic [KY_W-1:0] kky_q, kky_d;
    logic [X_W-1:0]  xx_q, xx_d;
    logic [Y_W-1:0]  yy_q, yy_d;
    logic [N_W-1:0]  nn_q, nn_d;
    logic [I_W-1:0]  ii_q, ii_d;

    logic mac_en_q;
    logic tile_done_q;

    logic load_cfg;
    logic zero_dim;
    logic advance;
    logic ii_last, kkx_last, kky_last, xx_last, yy_last, nn_last;
    logic last_red, last_all;

    // Terminal conditions of each loop level, evaluated on the latched configuration.
    // The strided loops compare one bit wider so xx+X_STEP / nn+N_STEP cannot wrap.
    always_comb begin
        ii_last  = (ii_q == ic_q - I_W'(1));
        kkx_last = (kkx_q == kx_q - KX_W'(1));
        kky_last = (kky_q == ky_q - KY_W'(1));
        xx_last  = (({1'b0, xx_q} + (X_W+1)'(X_STEP)) >= {1'b0, x_q});
        yy_last  = (yy_q == y_q - Y_W'(1));
        nn_last  = (({1'b0, nn_q} + (N_W+1)'(N_STEP)) >= {1'b0, nc_q});
        last_red = ii_last & kkx_last & kky_last;
        last_all = last_red & xx_last & yy_last & nn_last;
    end

    // Issue qualifier and launch decode
    always_comb begin
        advance  = (state_q == StRun) & ~sparse_stall & mult_done;
        zero_dim = (kx == '0) | (ky == '0) | (x == '0) | (y == '0) | (nc == '0) | (ic == '0);
    end

    // FSM next-state; a layer with any empty dimension goes straight to DONE
    always_comb begin
        state_d  = state_q;
        load_cfg = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load_cfg = 1'b1;
                    state_d  = zero_dim ? StDone : StRun;
                end
            end
            StRun: begin
                if (advance && last_all) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counter next-state: innermost ii first, carrying outward on wrap.
    // On the final read the counters hold so the last indices stay visible.
    always_comb begin
        kkx_d = kkx_q;
        kky_d = kky_q;
        xx_d  = xx_q;
        yy_d  = yy_q;
        nn_d  = nn_q;
        ii_d  = ii_q;
        if (load_cfg) begin
            kkx_d = '0;
            kky_d = '0;
            xx_d  = '0;
            yy_d  = '0;
            nn_d  = '0;
            ii_d  = '0;
        end else if (advance && !last_all) begin
            if (!ii_last) begin
                ii_d = ii_q + I_W'(1);
            end else begin
                ii_d = '0;
                if (!kkx_last) begin
                    kkx_d = kkx_q + KX_W'(1);
                end else begin
                    kkx_d = '0;
                    if (!kky_last) begin
                        kky_d = kky_q + KY_W'(1);
                    end else begin
                        kky_d = '0;
                        if (!xx_last) begin
                            xx_d = xx_q + X_W'(X_STEP);
                        end else begin
                            xx_d = '0;
                            if (!yy_last) begin
                                yy_d = yy_q + Y_W'(1);
                            end else begin
                                yy_d = '0;
                                nn_d = nn_q + N_W'(N_STEP);
                            end
                        end
                    end
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration latch, written only when a start is accepted in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            kx_q <= '0;
            ky_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
            nc_q <= '0;
            ic_q <= '0;
        end else if (load_cfg) begin
            kx_q <= kx;
            ky_q <= ky;
            x_q  <= x;
            y_q  <= y;
            nc_q <= nc;
            ic_q <= ic;
        end
    end

    // Index counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            kkx_q <= '0;
            kky_q <= '0;
            xx_q  <= '0;
            yy_q  <= '0;
            nn_q  <= '0;
            ii_q  <= '0;
        end else begin
            kkx_q <= kkx_d;
            kky_q <= kky_d;
            xx_q  <= xx_d;
            yy_q  <= yy_d;
            nn_q  <= nn_d;
            ii_q  <= ii_d;
        end
    end

    // MAC strobes lag the read by one cycle to line up with the registered buffer data
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_en_q    <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            mac_en_q    <= buf_rd_en;
            tile_done_q <= buf_rd_en & last_red;
        end
    end

    // Output mapping
    always_comb begin
        buf_rd_en      = advance;
        busy           = (state_q != StIdle);
        done           = (state_q == StDone);
        kkx            = kkx_q;
        kky            = kky_q;
        xx             = xx_q;
        yy             = yy_q;
        nn             = nn_q;
        ii             = ii_q;
        mac_en         = mac_en_q;
        tile_done_flag = tile_done_q;
    end

endmodule
